// File: rtl/core_ma_lsu_receive_data_if.sv
// Handshake and data bus bundle for the LSU load-data receive block.
// slave: the receive block itself; master: the side driving descriptors,
// Avalon beats and consuming results.
interface core_ma_lsu_receive_data_if;
    logic        ld_valid;
    logic        ld_ready;
    logic [1:0]  ld_addr_lo;
    logic [2:0]  ld_op_type;
    logic [2:0]  ld_data_len;
    logic [31:0] avl_m0_read_data;
    logic        avl_m0_read_data_valid;
    logic        load_valid;
    logic        load_ready;
    logic [31:0] load_data;
    logic        load_misalign;

    modport slave (
        input  ld_valid, ld_addr_lo, ld_op_type, ld_data_len,
        input  avl_m0_read_data, avl_m0_read_data_valid, load_ready,
        output ld_ready, load_valid, load_data, load_misalign
    );

    modport master (
        output ld_valid, ld_addr_lo, ld_op_type, ld_data_len,
        output avl_m0_read_data, avl_m0_read_data_valid, load_ready,
        input  ld_ready, load_valid, load_data, load_misalign
    );
endinterface

// File: rtl/core_ma_lsu_receive_data.sv
// Load-data receive path: accepts a load descriptor, collects one or two
// Avalon read beats, aligns and sign/zero-extends the result and holds it
// until the consumer takes it. Beats arriving with no load outstanding are
// dropped and counted in a saturating counter.
// Optional feature macro CORE_LSU_MISALIGN_EN: when defined, word-crossing
// loads fetch two beats; when undefined they complete at once as a
// misalignment exception without consuming any beat.
module core_ma_lsu_receive_data #(
    parameter int ERR_CNT_W = 8
) (
    input  logic                      clk,
    input  logic                      rest,
    core_ma_lsu_receive_data_if.slave lsu,
    output logic [ERR_CNT_W-1:0]      orphan_cnt
);

`ifdef CORE_LSU_MISALIGN_EN
    typedef enum logic [1:0] {IDLE = 2'd0, BEAT0 = 2'd1, BEAT1 = 2'd2, DONE = 2'd3} state_e;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, BEAT0 = 2'd1, DONE = 2'd3} state_e;
`endif

    state_e               state_q, state_d;
    logic [1:0]           addr_lo_q, addr_lo_d;
    logic [2:0]           op_type_q, op_type_d;
    logic [2:0]           data_len_q, data_len_d;
    logic [31:0]          word0_q, word0_d;
    logic                 load_valid_q, load_valid_d;
    logic [31:0]          load_data_q, load_data_d;
    logic [ERR_CNT_W-1:0] orphan_q, orphan_d;
`ifdef CORE_LSU_MISALIGN_EN
    logic                 two_beat_q, two_beat_d;
    logic [31:0]          word1_q, word1_d;
`else
    logic                 misalign_q, misalign_d;
`endif

    logic        accept;
    logic        beat;
    logic        two_beat_in;
    logic        final_beat;
    logic [31:0] hi_word;
    logic [31:0] aligned;

    assign beat        = lsu.avl_m0_read_data_valid;
    assign accept      = lsu.ld_valid && (state_q == IDLE);
    // Access crosses the word boundary when offset + length exceeds 4 bytes
    assign two_beat_in = ({2'b00, lsu.ld_addr_lo} + {1'b0, lsu.ld_data_len}) > 4'd4;

    // Sign/zero extension by funct3; unknown funct3 zero-extends by length
    function automatic logic [31:0] extend(input logic [31:0] v, input logic [2:0] op,
                                           input logic [2:0] len);
        case (op)
            3'b000:  return {{24{v[7]}}, v[7:0]};
            3'b001:  return {{16{v[15]}}, v[15:0]};
            3'b010:  return v;
            3'b100:  return {24'b0, v[7:0]};
            3'b101:  return {16'b0, v[15:0]};
            default: begin
                case (len)
                    3'd1:    return {24'b0, v[7:0]};
                    3'd2:    return {16'b0, v[15:0]};
                    default: return v;
                endcase
            end
        endcase
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (rest) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
`ifdef CORE_LSU_MISALIGN_EN
                if (accept) state_d = BEAT0;
`else
                if (accept) state_d = two_beat_in ? DONE : BEAT0;
`endif
            end
            BEAT0: begin
`ifdef CORE_LSU_MISALIGN_EN
                if (beat) state_d = two_beat_q ? BEAT1 : DONE;
`else
                if (beat) state_d = DONE;
`endif
            end
`ifdef CORE_LSU_MISALIGN_EN
            BEAT1: if (beat) state_d = DONE;
`endif
            DONE:    if (load_valid_q && lsu.load_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs and datapath: capture descriptor and beats, form the result
    always_comb begin
        lsu.ld_ready = (state_q == IDLE);
        addr_lo_d    = addr_lo_q;
        op_type_d    = op_type_q;
        data_len_d   = data_len_q;
        word0_d      = word0_q;
        load_data_d  = load_data_q;
        final_beat   = 1'b0;
        hi_word      = '0;
`ifdef CORE_LSU_MISALIGN_EN
        two_beat_d   = two_beat_q;
        word1_d      = word1_q;
`else
        misalign_d   = misalign_q;
`endif

        if (accept) begin
            addr_lo_d  = lsu.ld_addr_lo;
            op_type_d  = lsu.ld_op_type;
            data_len_d = lsu.ld_data_len;
`ifdef CORE_LSU_MISALIGN_EN
            two_beat_d = two_beat_in;
`else
            misalign_d = two_beat_in;
            if (two_beat_in) load_data_d = '0;
`endif
        end

        if (state_q == BEAT0 && beat) begin
            word0_d = lsu.avl_m0_read_data;
`ifdef CORE_LSU_MISALIGN_EN
            final_beat = !two_beat_q;
`else
            final_beat = 1'b1;
`endif
        end
`ifdef CORE_LSU_MISALIGN_EN
        if (state_q == BEAT1 && beat) begin
            word1_d    = lsu.avl_m0_read_data;
            hi_word    = lsu.avl_m0_read_data;
            final_beat = 1'b1;
        end
`endif

        // Upper word is zero for single-beat loads, so one shifter serves both
        aligned = 32'({hi_word, word0_d} >> {addr_lo_q, 3'b000});
        if (final_beat) load_data_d = extend(aligned, op_type_q, data_len_q);

        // Result is valid exactly while the FSM sits in DONE
        load_valid_d = (state_d == DONE);
`ifndef CORE_LSU_MISALIGN_EN
        if (state_d == IDLE) misalign_d = 1'b0;
`endif

        orphan_d = orphan_q;
        if (beat && (state_q == IDLE || state_q == DONE) && (orphan_q != '1))
            orphan_d = orphan_q + ERR_CNT_W'(1);
    end

    // Descriptor, beat, result and orphan-counter registers
    always_ff @(posedge clk) begin
        if (rest) begin
            addr_lo_q    <= '0;
            op_type_q    <= '0;
            data_len_q   <= '0;
            word0_q      <= '0;
            load_valid_q <= 1'b0;
            load_data_q  <= '0;
            orphan_q     <= '0;
`ifdef CORE_LSU_MISALIGN_EN
            two_beat_q   <= 1'b0;
            word1_q      <= '0;
`else
            misalign_q   <= 1'b0;
`endif
        end else begin
            addr_lo_q    <= addr_lo_d;
            op_type_q    <= op_type_d;
            data_len_q   <= data_len_d;
            word0_q      <= word0_d;
            load_valid_q <= load_valid_d;
            load_data_q  <= load_data_d;
            orphan_q     <= orphan_d;
`ifdef CORE_LSU_MISALIGN_EN
            two_beat_q   <= two_beat_d;
            word1_q      <= word1_d;
`else
            misalign_q   <= misalign_d;
`endif
        end
    end

    assign lsu.load_valid = load_valid_q;
    assign lsu.load_data  = load_data_q;
`ifdef CORE_LSU_MISALIGN_EN
    assign lsu.load_misalign = 1'b0;
`else
    assign lsu.load_misalign = misalign_q;
`endif
    assign orphan_cnt = orphan_q;

endmodule

// File: tb/tb_core_ma_lsu_receive_data.sv
// Self-checking bench for core_ma_lsu_receive_data: directed cases plus
// randomized loads checked against a byte-arithmetic reference model.
// Small orphan counter width so saturation is reachable quickly.
module tb_core_ma_lsu_receive_data;
    localparam int W = 4;
`ifdef CORE_LSU_MISALIGN_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rest = 1'b1;
    logic [W-1:0] orphan_cnt;
    int           n_vec = 0;
    int           n_err = 0;
    int           exp_orphan = 0;

    core_ma_lsu_receive_data_if lsu ();
    core_ma_lsu_receive_data #(.ERR_CNT_W(W)) dut (
        .clk(clk), .rest(rest), .lsu(lsu), .orphan_cnt(orphan_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want $finish");
        $fatal(1);
    end

    // Reference: pick bytes out of the 64-bit little-endian pair, then extend
    function automatic logic [31:0] ref_load(input int op, input int off, input int len,
                                             input logic [31:0] w0, input logic [31:0] w1);
        longint unsigned dw, v, b, h;
        dw = {w1, w0};
        v  = (dw >> (8 * off)) & 64'hFFFF_FFFF;
        b  = v % 256;
        h  = v % 65536;
        case (op)
            0:       return (b >= 128) ? 32'(b + 64'hFFFF_FF00) : 32'(b);
            1:       return (h >= 32768) ? 32'(h + 64'hFFFF_0000) : 32'(h);
            2:       return 32'(v);
            4:       return 32'(b);
            5:       return 32'(h);
            default: return (len == 1) ? 32'(b) : (len == 2) ? 32'(h) : 32'(v);
        endcase
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic drive_desc(input int op, input int off, input int len);
        lsu.ld_valid    = 1'b1;
        lsu.ld_op_type  = 3'(op);
        lsu.ld_addr_lo  = 2'(off);
        lsu.ld_data_len = 3'(len);
        tick();
        lsu.ld_valid = 1'b0;
    endtask

    task automatic drive_beat(input logic [31:0] d, input bit orphan);
        lsu.avl_m0_read_data       = d;
        lsu.avl_m0_read_data_valid = 1'b1;
        tick();
        lsu.avl_m0_read_data_valid = 1'b0;
        if (orphan && exp_orphan < (1 << W) - 1) exp_orphan++;
    endtask

    task automatic consume();
        lsu.load_ready = 1'b1;
        tick();
        lsu.load_ready = 1'b0;
    endtask

    // Full load with gap idle cycles before each beat; samples result after last beat
    task automatic do_load(input int op, input int off, input int len,
                           input logic [31:0] w0, input logic [31:0] w1, input int gap,
                           output logic rdy, output logic v, output logic mis,
                           output logic [31:0] d);
        bit two;
        two = (off + len) > 4;
        rdy = lsu.ld_ready;
        drive_desc(op, off, len);
        if (!(two && !EN)) begin
            repeat (gap) tick();
            drive_beat(w0, 1'b0);
            if (two) begin
                repeat (gap) tick();
                drive_beat(w1, 1'b0);
            end
        end
        v   = lsu.load_valid;
        mis = lsu.load_misalign;
        d   = lsu.load_data;
    endtask

    task automatic test_reset();
        rest = 1'b1;
        repeat (2) tick();
        n_vec++; if (lsu.load_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", lsu.load_valid); end
        n_vec++; if (lsu.load_data !== 32'h0) begin n_err++; $display("FAIL reset_data: got %h want 0", lsu.load_data); end
        n_vec++; if (lsu.load_misalign !== 1'b0) begin n_err++; $display("FAIL reset_mis: got %b want 0", lsu.load_misalign); end
        n_vec++; if (orphan_cnt !== '0) begin n_err++; $display("FAIL reset_orphan: got %0d want 0", orphan_cnt); end
        rest = 1'b0;
        exp_orphan = 0;
        tick();
        n_vec++; if (lsu.ld_ready !== 1'b1) begin n_err++; $display("FAIL reset_ld_ready: got %b want 1", lsu.ld_ready); end
    endtask

    task automatic test_directed();
        logic r, v, m;
        logic [31:0] d;
        do_load(2, 0, 4, 32'h8899AABB, 32'h0, 0, r, v, m, d);
        n_vec++; if (v !== 1'b1 || d !== 32'h8899AABB || m !== 1'b0) begin n_err++; $display("FAIL lw_off0: got v=%b d=%h m=%b want v=1 d=8899aabb m=0", v, d, m); end
        consume();
        do_load(0, 3, 1, 32'h80112233, 32'h0, 1, r, v, m, d);
        n_vec++; if (v !== 1'b1 || d !== 32'hFFFFFF80) begin n_err++; $display("FAIL lb_off3: got v=%b d=%h want v=1 d=ffffff80", v, d); end
        consume();
        do_load(4, 3, 1, 32'h80112233, 32'h0, 0, r, v, m, d);
        n_vec++; if (v !== 1'b1 || d !== 32'h00000080) begin n_err++; $display("FAIL lbu_off3: got v=%b d=%h want v=1 d=00000080", v, d); end
        consume();
        do_load(1, 2, 2, 32'h9ABC1234, 32'h0, 0, r, v, m, d);
        n_vec++; if (d !== 32'hFFFF9ABC) begin n_err++; $display("FAIL lh_off2: got %h want ffff9abc", d); end
        consume();
    endtask

    task automatic test_two_beat();
        logic r, v, m;
        logic [31:0] d;
`ifdef CORE_LSU_MISALIGN_EN
        drive_desc(2, 2, 4);
        drive_beat(32'h44332211, 1'b0);
        n_vec++; if (lsu.load_valid !== 1'b0) begin n_err++; $display("FAIL two_beat_early: got %b want 0", lsu.load_valid); end
        drive_beat(32'h88776655, 1'b0);
        n_vec++; if (lsu.load_valid !== 1'b1 || lsu.load_data !== 32'h66554433 || lsu.load_misalign !== 1'b0) begin
            n_err++; $display("FAIL lw_off2_two_beat: got v=%b d=%h m=%b want v=1 d=66554433 m=0", lsu.load_valid, lsu.load_data, lsu.load_misalign); end
        consume();
`else
        do_load(1, 3, 2, 32'h0, 32'h0, 0, r, v, m, d);
        n_vec++; if (v !== 1'b1 || m !== 1'b1 || d !== 32'h0) begin n_err++; $display("FAIL lh_off3_misalign: got v=%b m=%b d=%h want v=1 m=1 d=0", v, m, d); end
        n_vec++; if (lsu.ld_ready !== 1'b0) begin n_err++; $display("FAIL misalign_busy: got %b want 0", lsu.ld_ready); end
        consume();
        n_vec++; if (lsu.ld_ready !== 1'b1 || lsu.load_valid !== 1'b0) begin n_err++; $display("FAIL misalign_release: got rdy=%b v=%b want rdy=1 v=0", lsu.ld_ready, lsu.load_valid); end
        // No beat was consumed, so the next one is an orphan
        drive_beat(32'h12345678, 1'b1);
        n_vec++; if (orphan_cnt !== W'(exp_orphan)) begin n_err++; $display("FAIL misalign_no_beat: got %0d want %0d", orphan_cnt, exp_orphan); end
`endif
    endtask

    task automatic test_hold();
        logic r, v, m;
        logic [31:0] d, w, e;
        w = $urandom();
        e = ref_load(1, 1, 2, w, 32'h0);
        do_load(1, 1, 2, w, 32'h0, 0, r, v, m, d);
        for (int i = 0; i < 5; i++) begin
            n_vec++; if (lsu.load_valid !== 1'b1 || lsu.load_data !== e || lsu.ld_ready !== 1'b0) begin
                n_err++; $display("FAIL hold_%0d: got v=%b d=%h rdy=%b want v=1 d=%h rdy=0", i, lsu.load_valid, lsu.load_data, lsu.ld_ready, e); end
            tick();
        end
        drive_beat(~w, 1'b1);
        n_vec++; if (orphan_cnt !== W'(exp_orphan) || lsu.load_data !== e || lsu.load_valid !== 1'b1) begin
            n_err++; $display("FAIL done_orphan: got cnt=%0d d=%h v=%b want cnt=%0d d=%h v=1", orphan_cnt, lsu.load_data, lsu.load_valid, exp_orphan, e); end
        consume();
        n_vec++; if (lsu.load_valid !== 1'b0) begin n_err++; $display("FAIL hold_release: got %b want 0", lsu.load_valid); end
    endtask

    task automatic test_back_to_back();
        logic r, v, m;
        logic [31:0] d;
        // Descriptor and beat in the same IDLE cycle: beat is an orphan
        lsu.ld_valid = 1'b1; lsu.ld_op_type = 3'd2; lsu.ld_addr_lo = 2'd0; lsu.ld_data_len = 3'd4;
        lsu.avl_m0_read_data = 32'hDEADBEEF; lsu.avl_m0_read_data_valid = 1'b1;
        tick();
        lsu.ld_valid = 1'b0; lsu.avl_m0_read_data_valid = 1'b0;
        if (exp_orphan < (1 << W) - 1) exp_orphan++;
        n_vec++; if (orphan_cnt !== W'(exp_orphan) || lsu.ld_ready !== 1'b0) begin
            n_err++; $display("FAIL same_cycle: got cnt=%0d rdy=%b want cnt=%0d rdy=0", orphan_cnt, lsu.ld_ready, exp_orphan); end
        drive_beat(32'hCAFEF00D, 1'b0);
        n_vec++; if (lsu.load_valid !== 1'b1 || lsu.load_data !== 32'hCAFEF00D) begin
            n_err++; $display("FAIL same_cycle_load: got v=%b d=%h want v=1 d=cafef00d", lsu.load_valid, lsu.load_data); end
        consume();
        do_load(5, 0, 2, 32'h0000F00D, 32'h0, 0, r, v, m, d);
        n_vec++; if (r !== 1'b1 || v !== 1'b1 || d !== 32'h0000F00D) begin
            n_err++; $display("FAIL b2b: got rdy=%b v=%b d=%h want rdy=1 v=1 d=0000f00d", r, v, d); end
        consume();
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 20; i++) drive_beat($urandom(), 1'b1);
        n_vec++; if (orphan_cnt !== W'(exp_orphan) || exp_orphan != (1 << W) - 1) begin
            n_err++; $display("FAIL orphan_saturate: got %0d want %0d", orphan_cnt, (1 << W) - 1); end
    endtask

    task automatic test_reset_mid();
        drive_desc(2, EN ? 2 : 0, 4);
        if (EN) drive_beat(32'h11111111, 1'b0);
        rest = 1'b1;
        tick();
        rest = 1'b0;
        exp_orphan = 0;
        n_vec++; if (lsu.load_valid !== 1'b0 || lsu.ld_ready !== 1'b1 || orphan_cnt !== '0) begin
            n_err++; $display("FAIL reset_mid: got v=%b rdy=%b cnt=%0d want v=0 rdy=1 cnt=0", lsu.load_valid, lsu.ld_ready, orphan_cnt); end
        drive_beat(32'h22222222, 1'b1);
        n_vec++; if (orphan_cnt !== W'(exp_orphan) || lsu.load_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_mid_orphan: got cnt=%0d v=%b want cnt=%0d v=0", orphan_cnt, lsu.load_valid, exp_orphan); end
    endtask

    task automatic test_random();
        int ops[8] = '{0, 1, 2, 4, 5, 3, 6, 7};
        int lens[3] = '{1, 2, 4};
        int op, off, len;
        bit two;
        logic r, v, m, em;
        logic [31:0] d, w0, w1, e;
        for (int n = 0; n < 60; n++) begin
            op  = ops[$urandom_range(0, 7)];
            off = $urandom_range(0, 3);
            len = (op == 0 || op == 4) ? 1 : (op == 1 || op == 5) ? 2 : (op == 2) ? 4 : lens[$urandom_range(0, 2)];
            w0  = $urandom();
            w1  = $urandom();
            two = (off + len) > 4;
            em  = two && !EN;
            e   = em ? 32'h0 : ref_load(op, off, len, w0, two ? w1 : 32'h0);
            do_load(op, off, len, w0, w1, $urandom_range(0, 2), r, v, m, d);
            n_vec++; if (r !== 1'b1 || v !== 1'b1 || m !== em || d !== e) begin
                n_err++; $display("FAIL rand_%0d op=%0d off=%0d len=%0d: got rdy=%b v=%b m=%b d=%h want rdy=1 v=1 m=%b d=%h",
                                  n, op, off, len, r, v, m, d, em, e); end
            if ($urandom_range(0, 3) == 0) drive_beat($urandom(), 1'b1);
            repeat ($urandom_range(0, 2)) tick();
            n_vec++; if (lsu.load_data !== e || lsu.load_valid !== 1'b1) begin
                n_err++; $display("FAIL rand_hold_%0d: got v=%b d=%h want v=1 d=%h", n, lsu.load_valid, lsu.load_data, e); end
            consume();
            n_vec++; if (orphan_cnt !== W'(exp_orphan) || lsu.load_valid !== 1'b0) begin
                n_err++; $display("FAIL rand_end_%0d: got cnt=%0d v=%b want cnt=%0d v=0", n, orphan_cnt, lsu.load_valid, exp_orphan); end
        end
    endtask

    initial begin
        lsu.ld_valid = 1'b0;
        lsu.ld_addr_lo = '0;
        lsu.ld_op_type = '0;
        lsu.ld_data_len = '0;
        lsu.avl_m0_read_data = '0;
        lsu.avl_m0_read_data_valid = 1'b0;
        lsu.load_ready = 1'b0;
        test_reset();
        test_directed();
        test_two_beat();
        test_hold();
        test_back_to_back();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
